// File: rtl/tx_frame_8b10b.sv
// Transmit framer feeding a combinational 8b/10b encoder; owns the running disparity.
// Optional frame/error counters are enabled by defining TX_FRAME_STATS_EN.
module tx_frame_8b10b #(
    parameter int IFG_MIN = 2,
    parameter int MAX_LEN = 1518,
    parameter int LEN_W   = 11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        sym_en,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    input  logic        s_last,
    output logic        s_ready,
    output logic [8:0]  enc_datain,
    output logic        enc_dispin,
    input  logic        enc_dispout,
    output logic        frame_err,
`ifdef TX_FRAME_STATS_EN
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt,
`endif
    output logic [2:0]  dbg_state
);

    localparam logic [8:0] SYM_K28_5 = 9'h1BC;
    localparam logic [8:0] SYM_D16_2 = 9'h050;
    localparam logic [8:0] SYM_SOP   = 9'h1FB;
    localparam logic [8:0] SYM_EOP   = 9'h1FD;
    localparam logic [8:0] SYM_ERR   = 9'h1FE;

    localparam int                IC_W    = $clog2(IFG_MIN + 2);
    localparam logic [IC_W-1:0]   IFG_LIM = IC_W'(IFG_MIN);
    localparam logic [LEN_W-1:0]  LEN_LIM = LEN_W'(MAX_LEN);

    typedef enum logic [2:0] {
        ST_IDLE_K = 3'd0,
        ST_IDLE_D = 3'd1,
        ST_SOP    = 3'd2,
        ST_DATA   = 3'd3,
        ST_EOP    = 3'd4,
        ST_ERR    = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [8:0]        data_q, data_d;
    logic              rd_q, rd_d;
    logic [IC_W-1:0]   idle_cnt_q, idle_cnt_d;
    logic [LEN_W-1:0]  len_q, len_d;
    logic              drop_q, drop_d;
    logic              last_q, last_d;
    logic              frame_err_q, frame_err_d;
    logic              in_frame;
    logic              accept;

    // Handshake: a byte moves on a clk edge where s_valid and s_ready are both high.
    // s_ready is only raised together with sym_en, so every transfer lands on a symbol slot.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        rd_d        = rd_q;
        idle_cnt_d  = idle_cnt_q;
        len_d       = len_q;
        drop_d      = drop_q;
        last_d      = last_q;
        frame_err_d = 1'b0;

        in_frame = (state_q == ST_SOP) || (state_q == ST_DATA);
        s_ready  = sym_en & ((in_frame & ~last_q & (len_q < LEN_LIM)) | drop_q);
        accept   = s_valid & s_ready;

        if (sym_en) begin
            rd_d = enc_dispout;
            if (drop_q && accept && s_last) begin
                drop_d = 1'b0;
            end

            case (state_q)
                ST_IDLE_K: begin
                    state_d = ST_IDLE_D;
                    if (idle_cnt_q < IFG_LIM) begin
                        idle_cnt_d = idle_cnt_q + IC_W'(1);
                    end
                end
                ST_IDLE_D: begin
                    if (s_valid && (idle_cnt_q >= IFG_LIM) && !drop_q) begin
                        state_d = ST_SOP;
                    end else begin
                        state_d = ST_IDLE_K;
                    end
                end
                ST_SOP, ST_DATA: begin
                    // A last byte wins over the length limit: it closes a legal frame.
                    if (state_q == ST_DATA && last_q) begin
                        state_d = ST_EOP;
                    end else if (state_q == ST_DATA && len_q == LEN_LIM) begin
                        state_d = ST_ERR;
                        drop_d  = 1'b1;
                    end else if (s_valid) begin
                        state_d = ST_DATA;
                        len_d   = len_q + LEN_W'(1);
                        last_d  = s_last;
                    end else begin
                        state_d = ST_ERR;
                    end
                end
                default: begin
                    state_d    = ST_IDLE_K;
                    idle_cnt_d = '0;
                    len_d      = '0;
                    last_d     = 1'b0;
                end
            endcase

            case (state_d)
                ST_IDLE_K: data_d = SYM_K28_5;
                ST_IDLE_D: data_d = SYM_D16_2;
                ST_SOP:    data_d = SYM_SOP;
                ST_DATA:   data_d = {1'b0, s_data};
                ST_EOP:    data_d = SYM_EOP;
                default:   data_d = SYM_ERR;
            endcase

            frame_err_d = (state_d == ST_ERR);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE_K;
            data_q      <= SYM_K28_5;
            rd_q        <= 1'b0;
            idle_cnt_q  <= '0;
            len_q       <= '0;
            drop_q      <= 1'b0;
            last_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            data_q      <= data_d;
            rd_q        <= rd_d;
            idle_cnt_q  <= idle_cnt_d;
            len_q       <= len_d;
            drop_q      <= drop_d;
            last_q      <= last_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign enc_datain = data_q;
    assign enc_dispin = rd_q;
    assign frame_err  = frame_err_q;
    assign dbg_state  = state_q;

`ifdef TX_FRAME_STATS_EN
    logic [15:0] frame_cnt_q, frame_cnt_d;
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        frame_cnt_d = frame_cnt_q;
        err_cnt_d   = err_cnt_q;
        if (sym_en && state_d == ST_EOP) begin
            frame_cnt_d = frame_cnt_q + 16'd1;
        end
        if (frame_err_d) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt_q <= '0;
            err_cnt_q   <= '0;
        end else begin
            frame_cnt_q <= frame_cnt_d;
            err_cnt_q   <= err_cnt_d;
        end
    end

    assign frame_cnt = frame_cnt_q;
    assign err_cnt   = err_cnt_q;
`endif

endmodule

// File: tb/tb_tx_frame_8b10b.sv
// Bench for tx_frame_8b10b: random frames and symbol strobes, frame-level reference
// model feeding an expected-symbol queue, monitor checks every consumed symbol slot.
module tb_tx_frame_8b10b;

  localparam int IFG_MIN = 2;
  localparam int MAX_LEN = 4;
  localparam int LEN_W   = 4;

  localparam logic [8:0] K_IDLE = 9'h1BC;
  localparam logic [8:0] D_IDLE = 9'h050;
  localparam logic [8:0] K_SOP  = 9'h1FB;
  localparam logic [8:0] K_EOP  = 9'h1FD;
  localparam logic [8:0] K_ERR  = 9'h1FE;

  logic        clk;
  logic        rst_n;
  logic        sym_en;
  logic [7:0]  s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [8:0]  enc_datain;
  logic        enc_dispin;
  logic        enc_dispout;
  logic        frame_err;
  logic [2:0]  dbg_state;
`ifdef TX_FRAME_STATS_EN
  logic [15:0] frame_cnt;
  logic [15:0] err_cnt;
`endif

  tx_frame_8b10b #(
    .IFG_MIN(IFG_MIN),
    .MAX_LEN(MAX_LEN),
    .LEN_W  (LEN_W)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sym_en     (sym_en),
    .s_data     (s_data),
    .s_valid    (s_valid),
    .s_last     (s_last),
    .s_ready    (s_ready),
    .enc_datain (enc_datain),
    .enc_dispin (enc_dispin),
    .enc_dispout(enc_dispout),
    .frame_err  (frame_err),
`ifdef TX_FRAME_STATS_EN
    .frame_cnt  (frame_cnt),
    .err_cnt    (err_cnt),
`endif
    .dbg_state  (dbg_state)
  );

  // Stand-in encoder: disparity flips on odd-parity symbols.
  assign enc_dispout = enc_dispin ^ (^enc_datain);

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- bookkeeping ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [8:0] exp_q[$];
  int exp_errs = 0, got_errs = 0;
  int exp_bytes = 0, got_bytes = 0;
  int exp_frames_sr = 0, exp_errs_sr = 0;
  int sym_mode = 0;
  int clk_cnt = 0;
  logic [7:0] fb[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- symbol strobe generator ----------------
  initial begin
    sym_en = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      clk_cnt++;
      case (sym_mode)
        0:       sym_en = 1'b1;
        1:       sym_en = ((clk_cnt % 10) == 0);
        default: sym_en = ($urandom_range(0, 2) == 0);
      endcase
    end
  end

  // ---------------- monitor / scoreboard ----------------
  logic       in_frame, idle_exp_k, prev_was_d, model_rd;
  int         pairs;
  logic       have_prev, prev_sym_en, prev_fe, prev_rd;
  logic [8:0] prev_dat;

  task automatic pop_compare(input logic [8:0] act, output logic [8:0] exp_sym);
    if (exp_q.size() == 0) begin
      n_checks++;
      n_fail++;
      exp_sym = act;
      $display("FAIL frame_sym: got %0h, expected no symbol (queue empty)", act);
    end else begin
      exp_sym = exp_q.pop_front();
      check("frame_sym", act, exp_sym);
    end
  endtask

  initial begin
    logic [8:0] sym, exp_sym;
    in_frame = 0; idle_exp_k = 1; prev_was_d = 0; model_rd = 0; pairs = 0;
    have_prev = 0; prev_sym_en = 0; prev_fe = 0; prev_rd = 0; prev_dat = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        in_frame = 0; idle_exp_k = 1; prev_was_d = 0; model_rd = 0; pairs = 0;
        have_prev = 0; prev_fe = 0;
      end else begin
        sym = enc_datain;
        if (have_prev && !prev_sym_en) begin
          check("hold_sym", sym, prev_dat);
          check("hold_rd", enc_dispin, prev_rd);
        end
        if (!sym_en) check("ready_without_strobe", s_ready, 0);
        if (frame_err) begin
          got_errs++;
          check("err_pulse_sym", sym, K_ERR);
          check("err_pulse_width", prev_fe, 0);
        end
        if (s_valid && s_ready) got_bytes++;
        if (sym_en) begin
          check("dispin", enc_dispin, model_rd);
          if (!in_frame) begin
            if (sym === K_SOP) begin
              check("sop_after_idle_d", prev_was_d, 1);
              check("sop_ifg_met", (pairs >= IFG_MIN), 1);
              pop_compare(sym, exp_sym);
              in_frame = 1;
            end else if (idle_exp_k) begin
              check("idle_k", sym, K_IDLE);
              exp_sym = K_IDLE;
              idle_exp_k = 0;
              prev_was_d = 0;
            end else begin
              check("idle_d", sym, D_IDLE);
              exp_sym = D_IDLE;
              idle_exp_k = 1;
              prev_was_d = 1;
              pairs++;
            end
          end else begin
            pop_compare(sym, exp_sym);
            if (sym === K_EOP || sym === K_ERR) begin
              in_frame = 0; pairs = 0; idle_exp_k = 1; prev_was_d = 0;
            end
          end
          model_rd = model_rd ^ (^exp_sym);
        end
        have_prev   = 1;
        prev_sym_en = sym_en;
        prev_dat    = sym;
        prev_rd     = enc_dispin;
        prev_fe     = frame_err;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_handshake();
    int t = 0;
    logic hs = 0;
    while (!hs) begin
      @(negedge clk);
      hs = s_valid && s_ready;
      @(posedge clk);
      #1;
      t++;
      if (!hs && t > 2000) begin
        n_checks++;
        n_fail++;
        $display("FAIL handshake_timeout: no s_ready after %0d cycles, expected acceptance", t);
        hs = 1;
      end
    end
  endtask

  task automatic drain(input string name);
    int t = 0;
    while (exp_q.size() != 0 && t < 3000) begin
      @(posedge clk);
      t++;
    end
    check(name, exp_q.size(), 0);
  endtask

  task automatic rand_fill(input int n);
    for (int i = 0; i < n; i++) fb[i] = 8'($urandom_range(0, 255));
  endtask

  // cut > 0: source withdraws after cut bytes (underrun); else n bytes with s_last on the final one.
  task automatic send_frame(input int n, input int cut);
    int nsend;
    exp_q.push_back(K_SOP);
    if (cut > 0) begin
      for (int i = 0; i < cut; i++) exp_q.push_back({1'b0, fb[i]});
      exp_q.push_back(K_ERR);
      exp_errs++; exp_errs_sr++;
      nsend = cut;
    end else if (n > MAX_LEN) begin
      for (int i = 0; i < MAX_LEN; i++) exp_q.push_back({1'b0, fb[i]});
      exp_q.push_back(K_ERR);
      exp_errs++; exp_errs_sr++;
      nsend = n;
    end else begin
      for (int i = 0; i < n; i++) exp_q.push_back({1'b0, fb[i]});
      exp_q.push_back(K_EOP);
      exp_frames_sr++;
      nsend = n;
    end
    exp_bytes += nsend;
    for (int i = 0; i < nsend; i++) begin
      s_data  = fb[i];
      s_valid = 1'b1;
      s_last  = (cut == 0) && (i == n - 1);
      wait_handshake();
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    if (cut > 0) drain("underrun_drain");
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #900000;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // ---------------- main sequence ----------------
  initial begin
    int n, cut, lim;
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_last = 1'b0;
    #12;
    check("rst_datain", enc_datain, K_IDLE);
    check("rst_dispin", enc_dispin, 0);
    check("rst_frame_err", frame_err, 0);
    check("rst_s_ready", s_ready, 0);
`ifdef TX_FRAME_STATS_EN
    check("rst_frame_cnt", frame_cnt, 0);
    check("rst_err_cnt", err_cnt, 0);
`endif
    @(posedge clk); #2;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);

    // directed, continuous strobe
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    send_frame(4, 0);
    rand_fill(5); send_frame(5, 2);
    rand_fill(3); send_frame(3, 0);
    rand_fill(6); send_frame(6, 0);
    rand_fill(2); send_frame(2, 0);
    drain("directed_drain");

    // strobe every 10th clock
    sym_mode = 1;
    fb[0] = 8'h11; fb[1] = 8'h22; fb[2] = 8'h33; fb[3] = 8'h44;
    send_frame(4, 0);
    rand_fill(7); send_frame(7, 0);
    rand_fill(1); send_frame(1, 0);
    drain("slow_strobe_drain");

    // random strobe and random frames
    sym_mode = 2;
    for (int f = 0; f < 30; f++) begin
      n = $urandom_range(1, 7);
      cut = 0;
      if (n >= 2 && $urandom_range(0, 3) == 0) begin
        lim = (n - 1 < MAX_LEN - 1) ? n - 1 : MAX_LEN - 1;
        cut = $urandom_range(1, lim);
      end
      rand_fill(n);
      send_frame(n, cut);
      if ($urandom_range(0, 2) == 0) repeat ($urandom_range(1, 15)) @(posedge clk);
    end
    drain("random_drain");

    // reset in the middle of a frame
    sym_mode = 0;
    repeat (3) @(posedge clk);
    exp_q.push_back(K_SOP);
    exp_q.push_back(9'h0A5);
    s_data = 8'hA5; s_valid = 1'b1; s_last = 1'b0;
    begin
      int t = 0;
      while (exp_q.size() != 0 && t < 200) begin
        @(posedge clk);
        t++;
      end
      check("pre_reset_in_frame", exp_q.size(), 0);
    end
    #3;
    rst_n = 1'b0;
    #1;
    check("midrst_datain", enc_datain, K_IDLE);
    check("midrst_dispin", enc_dispin, 0);
    check("midrst_s_ready", s_ready, 0);
    check("midrst_frame_err", frame_err, 0);
`ifdef TX_FRAME_STATS_EN
    check("midrst_frame_cnt", frame_cnt, 0);
    check("midrst_err_cnt", err_cnt, 0);
`endif
    s_valid = 1'b0;
    exp_q.delete();
    exp_bytes += 2;
    exp_frames_sr = 0;
    exp_errs_sr = 0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;

    rand_fill(4); send_frame(4, 0);
    rand_fill(6); send_frame(6, 0);
    rand_fill(3); send_frame(3, 0);
    drain("final_drain");
    repeat (20) @(posedge clk);

    check("err_pulse_count", got_errs, exp_errs);
    check("accepted_bytes", got_bytes, exp_bytes);
`ifdef TX_FRAME_STATS_EN
    check("frame_cnt", frame_cnt, exp_frames_sr);
    check("err_cnt", err_cnt, exp_errs_sr);
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
